// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, START/DONE handshake.
// Divide by zero short-circuits straight to FIN with Q = all ones and R = A.
module seq_divider #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV_ZERO
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic             accept;
  logic             last_step;

  // The sign bit of the (WIDTH+1)-bit trial subtraction doubles as the >= compare.
  always_comb begin
    rem_shift = {rem, acc[WIDTH-1]};
    diff      = rem_shift - {1'b0, divisor};
    q_bit     = ~diff[WIDTH];
    rem_next  = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    last_step = (count == CW'(1));
  end

  always_comb begin
    next_state = state;
    BUSY       = 1'b1;
    DONE       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          accept     = 1'b1;
          next_state = (B == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (last_step) next_state = FIN;
      end
      FIN: begin
        DONE       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= next_state;
  end

  // acc starts as the dividend and fills with quotient bits as it shifts out.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc      <= '0;
      divisor  <= '0;
      rem      <= '0;
      count    <= '0;
      Q        <= '0;
      R        <= '0;
      DIV_ZERO <= 1'b0;
    end else if (accept) begin
      if (B == '0) begin
        Q        <= '1;
        R        <= A;
        DIV_ZERO <= 1'b1;
      end else begin
        acc     <= A;
        divisor <= B;
        rem     <= '0;
        count   <= CW'(WIDTH);
      end
    end else if (state == RUN) begin
      acc   <= {acc[WIDTH-2:0], q_bit};
      rem   <= rem_next;
      count <= count - CW'(1);
      if (last_step) begin
        Q        <= {acc[WIDTH-2:0], q_bit};
        R        <= rem_next;
        DIV_ZERO <= 1'b0;
      end
    end
  end

endmodule
